// File: rtl/freq_counter_pkg.sv
// Shared defaults and FSM state type for the
// frequency-counter BCD digit streamer.
package freq_counter_pkg;

  localparam int DIGITS_DEF    = 8;
  localparam int BIN_WIDTH_DEF = 27;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_streamer_if.sv
// Digit stream handshake toward the 7-segment stage.
// master drives digit_valid/out/index/blank; slave drives digit_ready.
interface bcd_digit_streamer_if;
  import freq_counter_pkg::*;

  logic             digit_valid;
  logic             digit_ready;
  logic [3:0]       digit_out;
  logic [IDX_W-1:0] digit_index;
  logic             digit_blank;

  modport master (
    output digit_valid,
    output digit_out,
    output digit_index,
    output digit_blank,
    input  digit_ready
  );

  modport slave (
    input  digit_valid,
    input  digit_out,
    input  digit_index,
    input  digit_blank,
    output digit_ready
  );

endinterface

// File: rtl/dabble_nibble_adjust.sv
// Double-dabble correction for one BCD nibble.
// nib_in: current nibble; nib_out: nib_in + 3 when nib_in >= 5.
module dabble_nibble_adjust (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bcd_digit_streamer.sv
// Binary count -> BCD via double dabble, streamed MSD first.
// Ports: clk, reset, start/value_in, busy, overflow, done, dig (master).
module bcd_digit_streamer
  import freq_counter_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] value_in,
  output logic                 busy,
  output logic                 overflow,
  output logic                 done,
  bcd_digit_streamer_if.master dig
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  localparam logic [BCD_W-1:0] ALL9 =
    {4'h0, {DIGITS{4'h9}}};

  state_t               state_q, state_n;
  logic [BCD_W-1:0]     bcd_q, bcd_n;
  logic [BIN_WIDTH-1:0] bin_q, bin_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 ovf_q, ovf_n;
  logic                 lead_q, lead_n;

  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     bcd_sh;
  logic [BIN_WIDTH-1:0] bin_sh;
  logic                 ovf_hit;
  logic [3:0]           cur;
  logic                 valid;

  for (genvar n = 0; n <= DIGITS; n++) begin : g_adj
    dabble_nibble_adjust u_adj (
      .nib_in  (bcd_q[4*n +: 4]),
      .nib_out (adj[4*n +: 4])
    );
  end

  assign bcd_sh = {adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
  assign bin_sh = {bin_q[BIN_WIDTH-2:0], 1'b0};

  // A carry out of the spare top nibble is also
  // treated as overflow, though it cannot occur
  // for the default widths.
  assign ovf_hit = adj[BCD_W-1]
                 | (bcd_sh[BCD_W-1 -: 4] != 4'd0);

  always_comb begin
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_n = state_q;
    bcd_n   = bcd_q;
    bin_n   = bin_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    ovf_n   = ovf_q;
    lead_n  = lead_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = CONVERT;
          bcd_n   = '0;
          bin_n   = value_in;
          cnt_n   = CNT_W'(BIN_WIDTH);
          idx_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      CONVERT: begin
        bcd_n = bcd_sh;
        bin_n = bin_sh;
        cnt_n = cnt_q - 1'b1;
        // Final iteration lands straight in STREAM
        // so the first digit appears one cycle later.
        if (cnt_q == CNT_W'(1)) begin
          state_n = STREAM;
          idx_n   = IDX_W'(DIGITS - 1);
          lead_n  = 1'b1;
          if (ovf_hit) begin
            ovf_n = 1'b1;
            bcd_n = ALL9;
          end
        end
      end
      STREAM: begin
        if (dig.digit_ready) begin
          lead_n = lead_q & (cur == 4'd0);
          if (idx_q == '0) state_n = DONE;
          else idx_n = idx_q - 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      lead_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      bcd_q   <= bcd_n;
      bin_q   <= bin_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      ovf_q   <= ovf_n;
      lead_q  <= lead_n;
    end
  end

  assign valid    = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

  assign dig.digit_valid = valid;
  assign dig.digit_out   = valid ? cur : 4'd0;
  assign dig.digit_index = idx_q;
  // lead_q: every more significant digit was zero.
  assign dig.digit_blank = valid & lead_q
                         & (cur == 4'd0)
                         & (idx_q != '0);

endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Scoreboard bench for bcd_digit_streamer.
// Directed vectors; negedge monitor pops expected digits.
module tb_bcd_digit_streamer;

  typedef struct {
    logic [3:0] d;
    logic [2:0] i;
    logic       b;
    logic       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [26:0] value_in = '0;
  logic        busy;
  logic        overflow;
  logic        done;

  bcd_digit_streamer_if dif ();

  bcd_digit_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value_in (value_in),
    .busy     (busy),
    .overflow (overflow),
    .done     (done),
    .dig      (dif)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_xfer_cyc = -100;
  int   rmode = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ready driver: 0 = always 1, 1 = 1,0,0,1 cycle,
  // 2 = left to the stimulus task.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    dif.digit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        dif.digit_ready = 1'b1;
      end else if (rmode == 1) begin
        dif.digit_ready = pat[k];
        k = (k + 1) % 4;
      end
    end
  end

  // monitor
  initial begin
    logic       held_v;
    logic [7:0] held;
    logic [7:0] now_s;
    exp_t       e;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      now_s = {dif.digit_out, dif.digit_index,
               dif.digit_blank};
      if (held_v && dif.digit_valid)
        chk("stall_hold", now_s, held);
      held_v = dif.digit_valid && !dif.digit_ready;
      held = now_s;
      if (dif.digit_valid && dif.digit_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_digit");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("digit_i%0d", e.i),
              {dif.digit_out, dif.digit_index,
               dif.digit_blank, overflow},
              {e.d, e.i, e.b, e.o});
          if (e.i == 3'd0) last_xfer_cyc = cyc;
        end
      end
    end
  end

  task automatic push_vec(input logic [31:0] bcd,
                          input logic [7:0] blank,
                          input logic ovf,
                          input int ndig);
    for (int i = 7; i > 7 - ndig; i--)
      exp_q.push_back('{bcd[4*i +: 4], 3'(i),
                        blank[i], ovf});
  endtask

  task automatic check_idle(input string name);
    chk(name,
        {busy, dif.digit_valid, done, overflow,
         dif.digit_out, dif.digit_index,
         dif.digit_blank},
        64'd0);
  endtask

  task automatic issue(input logic [26:0] v);
    @(posedge clk);
    #1;
    start = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value_in = 27'h5a5a5a;
  endtask

  task automatic run_vec(input logic [26:0] v,
                         input logic [31:0] bcd,
                         input logic [7:0] blank,
                         input logic ovf,
                         input int mode,
                         input bit inject);
    int n;
    rmode = mode;
    push_vec(bcd, blank, ovf, 8);
    issue(v);
    chk("busy_convert", busy, 1);
    n = 1;
    while (!dif.digit_valid && n < 60) begin
      if (inject && n == 10) begin
        start = 1'b1;
        value_in = 27'd555;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("first_valid_lat", n, 28);
    if (inject) begin
      start = 1'b1;
      value_in = 27'd777;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      fail_now("done_wait");
    end else begin
      chk("done_after_last", cyc, last_xfer_cyc + 1);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {done, busy}, 0);
      chk("ovf_hold", overflow, ovf);
    end
    chk("queue_empty", exp_q.size(), 0);
    rmode = 0;
  endtask

  task automatic reset_mid_stream();
    int n;
    rmode = 2;
    dif.digit_ready = 1'b1;
    push_vec(32'h87654321, 8'h00, 1'b0, 3);
    issue(27'd87654321);
    n = 0;
    while (!dif.digit_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (dif.digit_index != 3'd4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (dif.digit_index != 3'd4)
      fail_now("reach_index4");
    dif.digit_ready = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    value_in = 27'd42;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check_idle("reset_mid_stream");
    @(posedge clk);
    #1;
    check_idle("start_with_reset_dropped");
    chk("queue_empty_reset", exp_q.size(), 0);
    rmode = 0;
  endtask

  initial begin
    start = 1'b1;
    value_in = 27'd12345;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check_idle("reset_state");
    @(posedge clk);
    #1;
    check_idle("idle_after_reset");

    run_vec(27'd12345, 32'h00012345,
            8'b1110_0000, 1'b0, 0, 1'b0);
    run_vec(27'd0, 32'h00000000,
            8'b1111_1110, 1'b0, 0, 1'b0);
    run_vec(27'd100000000, 32'h99999999,
            8'b0000_0000, 1'b1, 0, 1'b0);
    run_vec(27'd7, 32'h00000007,
            8'b1111_1110, 1'b0, 0, 1'b0);
    run_vec(27'd99999999, 32'h99999999,
            8'b0000_0000, 1'b0, 1, 1'b0);
    run_vec(27'd905, 32'h00000905,
            8'b1111_1000, 1'b0, 1, 1'b0);
    run_vec(27'd10000000, 32'h10000000,
            8'b0000_0000, 1'b0, 0, 1'b0);
    run_vec(27'd134217727, 32'h99999999,
            8'b0000_0000, 1'b1, 0, 1'b0);
    run_vec(27'd4321, 32'h00004321,
            8'b1111_0000, 1'b0, 0, 1'b1);
    reset_mid_stream();
    run_vec(27'd4321, 32'h00004321,
            8'b1111_0000, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed",
             checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
